micro_tile_sched: RTL and testbench



---
 rtl/micro_tile_sched_pkg.sv | 18 +
 rtl/micro_tile_outmux.sv | 39 +++
 rtl/micro_tile_sched.sv | 146 ++++++++++++++
 tb/tb_micro_tile_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/micro_tile_sched_pkg.sv
// Shared types and default sizing for the micro-tile scheduler.
// Imported by the FSM top and the output mux.
package micro_tile_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_SETTLE,
    S_RUN
  } state_e;

  localparam int DEF_N_TILES       = 6;
  localparam int DEF_SEL_W         = 3;
  localparam int DEF_RST_CYCLES    = 4;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int TILE_W            = 8;

endpackage

// File: rtl/micro_tile_outmux.sv
// Registered N-to-1 byte mux for the shared output pads.
// Deasserting i_en forces the registered byte to zero.
module micro_tile_outmux
  import micro_tile_sched_pkg::*;
#(
  parameter int N_TILES = DEF_N_TILES,
  parameter int SEL_W   = DEF_SEL_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_en,
  input  logic [SEL_W-1:0]          i_sel,
  input  logic [TILE_W*N_TILES-1:0] i_tile_uo,
  output logic [TILE_W-1:0]         o_uo
);

  logic [TILE_W-1:0] w_byte;
  logic [TILE_W-1:0] r_uo;

  always_comb begin
    w_byte = '0;
    for (int i = 0; i < N_TILES; i++) begin
      if (i_sel == SEL_W'(i)) begin
        w_byte = i_tile_uo[i*TILE_W +: TILE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uo <= '0;
    end else begin
      r_uo <= i_en ? w_byte : '0;
    end
  end

  assign o_uo = r_uo;

endmodule

// File: rtl/micro_tile_sched.sv
// Shares one output byte among micro tiles: holds all but the
// selected tile in reset and sequences it through reset/settle.
module micro_tile_sched
  import micro_tile_sched_pkg::*;
#(
  parameter int N_TILES       = DEF_N_TILES,
  parameter int SEL_W         = DEF_SEL_W,
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  input  logic [SEL_W-1:0]          req_tile,
  output logic                      req_ready,
  input  logic [TILE_W*N_TILES-1:0] tile_uo,
  output logic [N_TILES-1:0]        tile_rst_n,
  output logic [TILE_W-1:0]         uo_out,
  output logic [SEL_W-1:0]          active_tile,
  output logic                      active_valid,
  output logic                      busy,
  output logic                      err
);

  localparam int CNT_MAX =
    (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W:0]   N_LIM    = (SEL_W+1)'(N_TILES);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [SEL_W-1:0]   r_active_tile;
  logic [SEL_W-1:0]   w_active_nxt;
  logic [N_TILES-1:0] r_tile_rst_n;
  logic [N_TILES-1:0] w_tile_rst_nxt;
  logic [N_TILES-1:0] w_onehot;
  logic               r_err;
  logic               w_err_nxt;
  logic               w_accept;
  logic               w_in_range;
  logic               w_uo_en;

  assign req_ready  = (r_state == S_IDLE) || (r_state == S_RUN);
  assign w_accept   = req_valid && req_ready;
  assign w_in_range = {1'b0, req_tile} < N_LIM;
  assign w_onehot   = N_TILES'(1) << r_active_tile;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_active_nxt   = r_active_tile;
    w_tile_rst_nxt = r_tile_rst_n;
    w_err_nxt      = 1'b0;
    w_uo_en        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_tile_rst_nxt = '0;
        if (w_accept) begin
          if (w_in_range) begin
            w_active_nxt = req_tile;
            w_cnt_nxt    = RST_LOAD;
            w_state_nxt  = S_RESET;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_RESET: begin
        w_tile_rst_nxt = '0;
        if (r_cnt == '0) begin
          w_tile_rst_nxt = w_onehot;
          w_cnt_nxt      = SET_LOAD;
          w_state_nxt    = S_SETTLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_RUN: begin
        w_uo_en = 1'b1;
        if (w_accept) begin
          // Any new request, even for the same tile, restarts cleanly.
          w_uo_en        = 1'b0;
          w_tile_rst_nxt = '0;
          if (w_in_range) begin
            w_active_nxt = req_tile;
            w_cnt_nxt    = RST_LOAD;
            w_state_nxt  = S_RESET;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_tile_rst_nxt = '0;
        w_state_nxt    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_active_tile <= '0;
      r_tile_rst_n  <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_active_tile <= w_active_nxt;
      r_tile_rst_n  <= w_tile_rst_nxt;
      r_err         <= w_err_nxt;
    end
  end

  micro_tile_outmux #(
    .N_TILES (N_TILES),
    .SEL_W   (SEL_W)
  ) u_outmux (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_uo_en),
    .i_sel     (r_active_tile),
    .i_tile_uo (tile_uo),
    .o_uo      (uo_out)
  );

  assign tile_rst_n   = r_tile_rst_n;
  assign active_tile  = r_active_tile;
  assign active_valid = (r_state == S_RUN);
  assign busy         = (r_state == S_RESET) || (r_state == S_SETTLE);
  assign err          = r_err;

endmodule

// File: tb/tb_micro_tile_sched.sv
// Directed bench for micro_tile_sched with hand-derived
// expected values at each clock edge after a request.
module tb_micro_tile_sched;

  localparam int N  = 6;
  localparam int SW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_valid = 1'b0;
  logic [SW-1:0]  req_tile = '0;
  logic [8*N-1:0] tile_uo = '0;
  logic           req_ready;
  logic [N-1:0]   tile_rst_n;
  logic [7:0]     uo_out;
  logic [SW-1:0]  active_tile;
  logic           active_valid;
  logic           busy;
  logic           err;

  int checks = 0;
  int failures = 0;

  micro_tile_sched #(
    .N_TILES       (N),
    .SEL_W         (SW),
    .RST_CYCLES    (4),
    .SETTLE_CYCLES (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_tile     (req_tile),
    .req_ready    (req_ready),
    .tile_uo      (tile_uo),
    .tile_rst_n   (tile_rst_n),
    .uo_out       (uo_out),
    .active_tile  (active_tile),
    .active_valid (active_valid),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [SW-1:0] t);
    req_valid = 1'b1;
    req_tile  = t;
    step(1);
    req_valid = 1'b0;
  endtask

  task automatic set_uo(input int i, input logic [7:0] v);
    tile_uo[8*i +: 8] = v;
  endtask

  initial begin
    #7;
    check("rst_trst", 32'(tile_rst_n), 32'h0);
    check("rst_uo", 32'(uo_out), 32'h0);
    check("rst_tile", 32'(active_tile), 32'h0);
    check("rst_av", 32'(active_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_rdy", 32'(req_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // first selection: tile 2
    set_uo(2, 8'hAA);
    req(3'd2);
    check("t1_busy0", 32'(busy), 32'h1);
    check("t1_rdy0", 32'(req_ready), 32'h0);
    check("t1_tile", 32'(active_tile), 32'h2);
    check("t1_trst0", 32'(tile_rst_n), 32'h0);
    for (int e = 1; e <= 3; e++) begin
      step(1);
      check("t1_trst_lo", 32'(tile_rst_n), 32'h0);
      check("t1_busy", 32'(busy), 32'h1);
    end
    step(1);
    check("t1_trst4", 32'(tile_rst_n), 32'h04);
    check("t1_av4", 32'(active_valid), 32'h0);
    step(1);
    check("t1_av5", 32'(active_valid), 32'h0);
    check("t1_uo5", 32'(uo_out), 32'h0);
    step(1);
    check("t1_av6", 32'(active_valid), 32'h1);
    check("t1_uo6", 32'(uo_out), 32'h0);
    check("t1_busy6", 32'(busy), 32'h0);
    check("t1_rdy6", 32'(req_ready), 32'h1);
    step(1);
    check("t1_uo7", 32'(uo_out), 32'hAA);

    // backpressure: tile 1 then tile 3 held from edge 2
    req(3'd1);
    step(1);
    req_valid = 1'b1;
    req_tile  = 3'd3;
    for (int e = 2; e <= 6; e++) begin
      step(1);
      check("t2_rdy", 32'(req_ready), (e < 6) ? 32'h0 : 32'h1);
      check("t2_tile", 32'(active_tile), 32'h1);
    end
    check("t2_trst6", 32'(tile_rst_n), 32'h02);
    step(1);
    req_valid = 1'b0;
    check("t2_tile7", 32'(active_tile), 32'h3);
    check("t2_trst7", 32'(tile_rst_n), 32'h0);
    check("t2_busy7", 32'(busy), 32'h1);
    step(3);
    check("t2_trst10", 32'(tile_rst_n), 32'h0);
    step(1);
    check("t2_trst11", 32'(tile_rst_n), 32'h08);
    step(2);
    check("t2_av13", 32'(active_valid), 32'h1);

    // same-tile restart on tile 0
    set_uo(0, 8'h0F);
    req(3'd0);
    step(7);
    check("t3_uo_run", 32'(uo_out), 32'h0F);
    check("t3_trst_run", 32'(tile_rst_n), 32'h01);
    req(3'd0);
    check("t3_uo_drop", 32'(uo_out), 32'h0);
    check("t3_trst_drop", 32'(tile_rst_n), 32'h0);
    check("t3_av_drop", 32'(active_valid), 32'h0);
    step(3);
    check("t3_trst3", 32'(tile_rst_n), 32'h0);
    step(1);
    check("t3_trst4", 32'(tile_rst_n), 32'h01);
    step(2);
    check("t3_uo6", 32'(uo_out), 32'h0);
    check("t3_av6", 32'(active_valid), 32'h1);
    step(1);
    check("t3_uo7", 32'(uo_out), 32'h0F);

    // out-of-range request while running
    req(3'd7);
    check("t4_err", 32'(err), 32'h1);
    check("t4_trst", 32'(tile_rst_n), 32'h0);
    check("t4_uo", 32'(uo_out), 32'h0);
    check("t4_av", 32'(active_valid), 32'h0);
    check("t4_tile", 32'(active_tile), 32'h0);
    check("t4_rdy", 32'(req_ready), 32'h1);
    check("t4_busy", 32'(busy), 32'h0);
    step(1);
    check("t4_err_clr", 32'(err), 32'h0);
    check("t4_uo_idle", 32'(uo_out), 32'h0);
    check("t4_trst_idle", 32'(tile_rst_n), 32'h0);

    // async reset during SETTLE
    set_uo(5, 8'h55);
    req(3'd5);
    step(4);
    check("t5_busy", 32'(busy), 32'h1);
    check("t5_trst", 32'(tile_rst_n), 32'h20);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_a_trst", 32'(tile_rst_n), 32'h0);
    check("t5_a_busy", 32'(busy), 32'h0);
    check("t5_a_tile", 32'(active_tile), 32'h0);
    check("t5_a_av", 32'(active_valid), 32'h0);
    check("t5_a_rdy", 32'(req_ready), 32'h1);
    #2;
    rst_n = 1'b1;
    step(1);
    check("t5_idle_trst", 32'(tile_rst_n), 32'h0);
    check("t5_idle_busy", 32'(busy), 32'h0);
    req(3'd5);
    step(3);
    check("t5_trst3", 32'(tile_rst_n), 32'h0);
    step(1);
    check("t5_trst4", 32'(tile_rst_n), 32'h20);
    step(1);
    check("t5_av5", 32'(active_valid), 32'h0);
    step(1);
    check("t5_av6", 32'(active_valid), 32'h1);
    step(1);
    check("t5_uo7", 32'(uo_out), 32'h55);

    // routing isolation on tile 4
    set_uo(4, 8'h12);
    req(3'd4);
    step(7);
    check("t6_uo_first", 32'(uo_out), 32'h12);
    for (int k = 0; k < 6; k++) begin
      logic [7:0] v;
      v = (k < 3) ? 8'h12 : 8'h34;
      for (int i = 0; i < N; i++) begin
        if (i != 4) set_uo(i, 8'($urandom));
      end
      set_uo(4, v);
      step(1);
      check("t6_track", 32'(uo_out), 32'(v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
